// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - matrix geometry (ROWS, COLS, NKEYS)
//   - row-scan state encoding and the matching active-low row drive patterns
//   - clog2 helper for sizing the scan divider and debounce counters
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NKEYS = ROWS * COLS;

  // One state per driven row; the encoding doubles as the row index.
  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } row_state_t;

  localparam logic [3:0] ROW_DRV_R0 = 4'b1110;
  localparam logic [3:0] ROW_DRV_R1 = 4'b1101;
  localparam logic [3:0] ROW_DRV_R2 = 4'b1011;
  localparam logic [3:0] ROW_DRV_R3 = 4'b0111;

  function automatic logic [3:0] row_drive(input row_state_t s);
    logic [3:0] drv;
    drv = ROW_DRV_R0;
    case (s)
      R0:      drv = ROW_DRV_R0;
      R1:      drv = ROW_DRV_R1;
      R2:      drv = ROW_DRV_R2;
      R3:      drv = ROW_DRV_R3;
      default: drv = ROW_DRV_R0;
    endcase
    return drv;
  endfunction

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Debounce state for a single key: a saturating-free agreement counter and
// the stable (reported) key state.  Only evaluated when i_tick_en is high,
// which happens once per full keypad scan for this key.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_tick_en    this key is being sampled this cycle
//   i_sample     raw sample, 1 = pressed
//   o_state      debounced state, 1 = held
//   o_state_nxt  value o_state takes at the next clock edge (lets the parent
//                build registered flags aligned with o_state)
// ---------------------------------------------------------------------------
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick_en,
  input  logic i_sample,
  output logic o_state,
  output logic o_state_nxt
);

  localparam int              CNT_W    = clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_state;
  logic             w_state_nxt;

  // A sample that agrees with the stable state wipes any partial count, so
  // only DEBOUNCE_CNT consecutive disagreeing samples flip the state.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (i_tick_en) begin
      if (i_sample == r_state) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_state_nxt = ~r_state;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/key_matrix_scan.sv
// ---------------------------------------------------------------------------
// key_matrix_scan
// 4x4 matrix keypad scanner with per-key debounce.  Drives one row low at a
// time, samples the synchronized columns at the end of each row dwell and
// feeds 16 independent debouncers.  Output bus feeds the piano beeper path.
//
// Ports:
//   clk        system clock (single domain)
//   rst_n      asynchronous active-low reset
//   col[3:0]   column lines, pulled up, low = pressed in driven row (async)
//   row[3:0]   row drive, active-low, exactly one bit low
//   key_out    debounced key state, bit row*4+col high = held
//   key_press  one-cycle pulse when any key_out bit rises
//   key_code   lowest set key_out index, 0 when none
// ---------------------------------------------------------------------------
module key_matrix_scan
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] key_out,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int               SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int               DIV_W    = clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Lowest set bit wins; 0 when nothing is set.
  function automatic logic [3:0] lowest_key(input logic [NKEYS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  row_state_t       r_state;
  row_state_t       w_state_nxt;
  logic [3:0]       r_row;
  logic [1:0]       w_row_idx;
  logic [NKEYS-1:0] w_key_state;
  logic [NKEYS-1:0] w_key_nxt;
  logic             r_press;
  logic [3:0]       r_code;

  // Column synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= 4'h0;
      r_col_sync <= 4'h0;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  // Row dwell divider; tick marks the last clock of each dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // Row FSM: state register plus registered row drive so the pins never
  // glitch while the state bits change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R0;
      r_row   <= ROW_DRV_R0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= row_drive(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        R0:      w_state_nxt = R1;
        R1:      w_state_nxt = R2;
        R2:      w_state_nxt = R3;
        R3:      w_state_nxt = R0;
        default: w_state_nxt = R0;
      endcase
    end
  end

  assign w_row_idx = r_state;
  assign row       = r_row;

  // Sampling uses the row still being driven: the tick is the final clock
  // of the dwell, so the row advance lands on the same edge as the sample.
  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    logic w_tick_en;
    logic w_sample;

    assign w_tick_en = w_tick && (w_row_idx == 2'(gi / COLS));
    assign w_sample  = ~r_col_sync[gi % COLS];

    key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_deb (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_tick_en   (w_tick_en),
      .i_sample    (w_sample),
      .o_state     (w_key_state[gi]),
      .o_state_nxt (w_key_nxt[gi])
    );
  end

  // Flags are derived from the debouncers' next state so they register on
  // the same edge that key_out changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_press <= |(w_key_nxt & ~w_key_state);
      r_code  <= lowest_key(w_key_nxt);
    end
  end

  assign key_out   = w_key_state;
  assign key_press = r_press;
  assign key_code  = r_code;

endmodule

// File: tb/tb_key_matrix_scan.sv
module tb_key_matrix_scan;

  localparam int SCAN_DIV = 10;
  localparam int DEB      = 3;
  localparam int SCAN     = 4 * SCAN_DIV;
  localparam int LAT      = 3 * SCAN + 12;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_out;
  logic        key_press;
  logic [3:0]  key_code;
  logic [15:0] held  = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int p0;

  always #5 clk = ~clk;

  key_matrix_scan #(
    .CLK_FREQ     (1000),
    .SCAN_HZ      (100),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_out   (key_out),
    .key_press (key_press),
    .key_code  (key_code)
  );

  // Keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (held[r*4+c]) col[c] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0]      out;
    logic [15:0][3:0] cnt;
  } mstate_t;

  function automatic mstate_t scan_step(input mstate_t s, input int r, input logic [3:0] pressed);
    mstate_t n;
    n = s;
    for (int c = 0; c < 4; c++) begin
      int i;
      i = r * 4 + c;
      if (pressed[c] == n.out[i]) n.cnt[i] = 4'd0;
      else if (n.cnt[i] == 4'(DEB - 1)) begin
        n.out[i] = ~n.out[i];
        n.cnt[i] = 4'd0;
      end else n.cnt[i] = n.cnt[i] + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] first_set(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  mstate_t     m       = '0;
  int unsigned k       = 0;     // clock edges since reset release
  logic [3:0]  col_d1  = 4'h0;  // col seen one edge ago
  logic [3:0]  col_d2  = 4'h0;  // col seen two edges ago
  logic        m_press = 1'b0;
  logic [3:0]  m_code  = 4'd0;
  logic [3:0]  m_row   = 4'b1110;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m = '0; k = 0; col_d1 = 4'h0; col_d2 = 4'h0;
      m_press = 1'b0; m_code = 4'd0; m_row = 4'b1110;
    end else begin
      mstate_t nx;
      logic [3:0] smp;
      smp = (k >= 2) ? ~col_d2 : 4'hF;
      col_d2 = col_d1;
      col_d1 = col;
      if (k % SCAN_DIV == SCAN_DIV - 1) begin
        nx      = scan_step(m, int'((k / SCAN_DIV) % 4), smp);
        m_press = |(nx.out & ~m.out);
        m_code  = first_set(nx.out);
        m       = nx;
      end else begin
        m_press = 1'b0;
      end
      k     = k + 1;
      m_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_row", 32'(row), 32'hE);
      chk("rst_key_out", 32'(key_out), 32'h0);
      chk("rst_key_press", 32'(key_press), 32'h0);
      chk("rst_key_code", 32'(key_code), 32'h0);
    end else begin
      chk("row", 32'(row), 32'(m_row));
      chk("key_out", 32'(key_out), 32'(m.out));
      chk("key_press", 32'(key_press), 32'(m_press));
      chk("key_code", 32'(key_code), 32'(m_code));
      if (key_press === 1'b1) pulses++;
    end
  end

  task automatic wait_key(input logic [15:0] exp, input int budget, input string nm);
    int n;
    n = 0;
    while (key_out !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(key_out), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clk);
    chk("reset_row_literal", 32'(row), 32'hE);
    rst_n = 1'b1;

    // idle rotation
    repeat (2 * SCAN) @(negedge clk);
    chk("idle_key_out", 32'(key_out), 32'h0);
    chk("idle_no_press", 32'(pulses), 32'd0);

    // single stable press of key 6
    p0   = pulses;
    held = 16'h0040;
    wait_key(16'h0040, LAT, "press6_key_out");
    chk("press6_code", 32'(key_code), 32'd6);
    chk("model_pin_press6", 32'(m.out), 32'h0040);
    repeat (5) @(negedge clk);
    chk("press6_one_pulse", 32'(pulses - p0), 32'd1);

    // bounce rejection
    held = 16'h0000;
    wait_key(16'h0000, LAT, "release6");
    p0 = pulses;
    for (int t = 0; t < 10; t++) begin
      held = (t % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (SCAN) @(negedge clk);
    end
    chk("bounce_key_out", 32'(key_out), 32'h0);
    chk("bounce_no_press", 32'(pulses - p0), 32'd0);
    held = 16'h0040;
    wait_key(16'h0040, LAT, "bounce_then_hold");

    // release and multi-key
    held = 16'h8001;
    wait_key(16'h8001, LAT, "multi_key_out");
    chk("multi_code", 32'(key_code), 32'd0);
    p0   = pulses;
    held = 16'h8000;
    wait_key(16'h8000, LAT, "release0_key_out");
    chk("release0_code", 32'(key_code), 32'd15);
    repeat (SCAN) @(negedge clk);
    chk("release_no_press", 32'(pulses - p0), 32'd0);

    // simultaneous rise of keys 4 and 5
    held = 16'h0000;
    wait_key(16'h0000, LAT, "clear_all");
    p0   = pulses;
    held = 16'h0030;
    wait_key(16'h0030, LAT, "simul_key_out");
    chk("simul_code", 32'(key_code), 32'd4);
    repeat (5) @(negedge clk);
    chk("simul_one_pulse", 32'(pulses - p0), 32'd1);

    // asynchronous reset mid-scan with divider at 5
    held = 16'h0040;
    wait_key(16'h0040, LAT, "pre_reset_key_out");
    while (k % SCAN_DIV != 5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_key_out", 32'(key_out), 32'h0);
    chk("async_rst_row", 32'(row), 32'hE);
    chk("async_rst_code", 32'(key_code), 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_key(16'h0040, LAT, "requalify_key_out");

    // randomized keypad activity
    held = 16'h0000;
    wait_key(16'h0000, LAT, "pre_random_clear");
    repeat (3000) begin
      int idx;
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        idx       = int'($urandom_range(0, 15));
        held[idx] = ~held[idx];
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
